// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared types and source indices for the TX response arbiter
// Source numbering matches bit positions of the pend/ovf vectors.
package tx_arb_pkg;

  localparam int NUM_SRC = 3;

  typedef logic [1:0] src_idx_t;

  localparam src_idx_t SRC_RF  = 2'd0;
  localparam src_idx_t SRC_ALU = 2'd1;
  localparam src_idx_t SRC_ACK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } tx_arb_state_e;

  function automatic src_idx_t gnt_idx(input logic [NUM_SRC-1:0] gnt);
    if (gnt[SRC_ALU]) return SRC_ALU;
    else if (gnt[SRC_ACK]) return SRC_ACK;
    else return SRC_RF;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - three-way round-robin grant, one-hot output
// Requests are rotated so the source after i_last sits at bit 0, then the lowest set bit wins.
module rr_arb3
  import tx_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  src_idx_t           i_last,
  output logic [NUM_SRC-1:0] o_gnt
);

  logic [NUM_SRC-1:0] w_rot;
  logic [NUM_SRC-1:0] w_rot_gnt;

  always_comb begin
    w_rot = i_req;
    case (i_last)
      SRC_RF:  w_rot = {i_req[SRC_RF],  i_req[SRC_ACK], i_req[SRC_ALU]};
      SRC_ALU: w_rot = {i_req[SRC_ALU], i_req[SRC_RF],  i_req[SRC_ACK]};
      default: w_rot = i_req;
    endcase
  end

  assign w_rot_gnt = w_rot & (~w_rot + 3'd1);

  always_comb begin
    o_gnt = w_rot_gnt;
    case (i_last)
      SRC_RF:  o_gnt = {w_rot_gnt[1], w_rot_gnt[0], w_rot_gnt[2]};
      SRC_ALU: o_gnt = {w_rot_gnt[0], w_rot_gnt[2], w_rot_gnt[1]};
      default: o_gnt = w_rot_gnt;
    endcase
  end

endmodule

// File: rtl/tx_resp_arbiter.sv
// rtl/tx_resp_arbiter.sv - one-entry response slots, round-robin grant and byte serializer to UART TX
// Optional REQ timeout is enabled with TX_ARB_TIMEOUT_EN.
module tx_resp_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_rf_data,
  input  logic                    i_rf_vld,
  input  logic [2*DATA_WIDTH-1:0] i_alu_data,
  input  logic                    i_alu_vld,
  input  logic [DATA_WIDTH-1:0]   i_ack_data,
  input  logic                    i_ack_vld,
  input  logic                    i_tx_busy,
  input  logic                    i_ovf_clr,
  output logic [DATA_WIDTH-1:0]   o_tx_p_data,
  output logic                    o_tx_d_vld,
  output logic [NUM_SRC-1:0]      o_pend,
  output logic [NUM_SRC-1:0]      o_ovf,
  output logic                    o_timeout_err
);

  tx_arb_state_e r_state, w_next_state;

  logic [NUM_SRC-1:0]      r_pend, r_ovf;
  logic [DATA_WIDTH-1:0]   r_rf_data, r_ack_data, r_tx_p_data, r_hi_byte;
  logic [2*DATA_WIDTH-1:0] r_alu_data;
  logic                    r_hi_pend;
  src_idx_t                r_last;

  logic [NUM_SRC-1:0]      w_gnt, w_free, w_vld, w_capture, w_ovf_set;
  logic                    w_grant_en, w_load, w_hi_take, w_frame_drop, w_timeout;
  logic [DATA_WIDTH-1:0]   w_load_data;

  rr_arb3 u_rr_arb3 (
    .i_req  (r_pend),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_en   = 1'b0;
    w_load       = 1'b0;
    w_load_data  = '0;
    w_hi_take    = 1'b0;
    w_frame_drop = 1'b0;
    case (r_state)
      IDLE: begin
        if (|r_pend) begin
          w_grant_en   = 1'b1;
          w_load       = 1'b1;
          w_next_state = REQ;
          if (w_gnt[SRC_ALU])      w_load_data = r_alu_data[DATA_WIDTH-1:0];
          else if (w_gnt[SRC_ACK]) w_load_data = r_ack_data;
          else                     w_load_data = r_rf_data;
        end
      end
      REQ: begin
        if (i_tx_busy) begin
          w_next_state = DRAIN;
        end else if (w_timeout) begin
          w_frame_drop = 1'b1;
          w_next_state = IDLE;
        end
      end
      DRAIN: begin
        if (!i_tx_busy) begin
          if (r_hi_pend) begin
            w_load       = 1'b1;
            w_load_data  = r_hi_byte;
            w_hi_take    = 1'b1;
            w_next_state = REQ;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // A slot is released on the grant edge, so a same-cycle vld refills it without overflow.
  assign w_free    = w_grant_en ? w_gnt : '0;
  assign w_vld     = {i_ack_vld, i_alu_vld, i_rf_vld};
  assign w_capture = w_vld & (~r_pend | w_free);
  assign w_ovf_set = w_vld & r_pend & ~w_free;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= '0;
      r_ovf      <= '0;
      r_rf_data  <= '0;
      r_alu_data <= '0;
      r_ack_data <= '0;
    end else begin
      r_pend <= (r_pend & ~w_free) | w_capture;
      r_ovf  <= (r_ovf & ~{NUM_SRC{i_ovf_clr}}) | w_ovf_set;
      if (w_capture[SRC_RF])  r_rf_data  <= i_rf_data;
      if (w_capture[SRC_ALU]) r_alu_data <= i_alu_data;
      if (w_capture[SRC_ACK]) r_ack_data <= i_ack_data;
    end
  end

  // The ALU high byte is copied out at grant because the slot may be refilled mid-frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last      <= SRC_ACK;
      r_hi_pend   <= 1'b0;
      r_hi_byte   <= '0;
      r_tx_p_data <= '0;
    end else begin
      if (w_grant_en) begin
        r_last    <= gnt_idx(w_gnt);
        r_hi_pend <= w_gnt[SRC_ALU];
        r_hi_byte <= r_alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
      end else if (w_hi_take || w_frame_drop) begin
        r_hi_pend <= 1'b0;
      end
      if (w_load) r_tx_p_data <= w_load_data;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_timeout_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_to_cnt      <= (r_state == REQ) ? r_to_cnt + 1'b1 : '0;
      r_timeout_err <= w_frame_drop;
    end
  end

  assign w_timeout     = (r_state == REQ) && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign o_timeout_err = r_timeout_err;
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign o_tx_p_data = r_tx_p_data;
  assign o_tx_d_vld  = (r_state == REQ);
  assign o_pend      = r_pend;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// tb/tb_tx_resp_arbiter.sv - scoreboard bench for tx_resp_arbiter with a UART busy model
// Define TX_ARB_TIMEOUT_EN to include the timeout scenario.
module tb_tx_resp_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rf_data, ack_data;
  logic [15:0] alu_data;
  logic        rf_vld, alu_vld, ack_vld, ovf_clr;
  logic        tx_busy;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld, timeout_err;
  logic [2:0]  pend, ovf;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       busy_hold = 1'b0;
  logic       model_en = 1'b1;
  logic       model_busy = 1'b0;
  int         model_cnt = 0;
  int         model_left = 0;
  int         to_count = 0;
  int         to_len = 0;

  always #5 clk = ~clk;
  assign tx_busy = busy_hold | model_busy;

  tx_resp_arbiter #(.DATA_WIDTH(8), .TIMEOUT_CYC(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rf_data     (rf_data),
    .i_rf_vld      (rf_vld),
    .i_alu_data    (alu_data),
    .i_alu_vld     (alu_vld),
    .i_ack_data    (ack_data),
    .i_ack_vld     (ack_vld),
    .i_tx_busy     (tx_busy),
    .i_ovf_clr     (ovf_clr),
    .o_tx_p_data   (tx_p_data),
    .o_tx_d_vld    (tx_d_vld),
    .o_pend        (pend),
    .o_ovf         (ovf),
    .o_timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] rd, input logic a, input logic [15:0] ad,
                       input logic k, input logic [7:0] kd);
    rf_vld = r; rf_data = rd; alu_vld = a; alu_data = ad; ack_vld = k; ack_data = kd;
  endtask

  task automatic pulse(input logic r, input logic [7:0] rd, input logic a, input logic [15:0] ad,
                       input logic k, input logic [7:0] kd);
    @(negedge clk);
    drive(r, rd, a, ad, k, kd);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 400) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && pend == 3'b000 && !tx_d_vld && !tx_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      checks++;
      errors++;
      $display("FAIL %s idle wait expired with %0d bytes outstanding", name, exp_q.size());
    end
  endtask

  task automatic wait_vld(input string name, input logic val);
    int n = 0;
    while (tx_d_vld !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx_d_vld !== val) begin
      checks++;
      errors++;
      $display("FAIL %s tx_d_vld got %b expected %b", name, tx_d_vld, val);
    end
  endtask

  // UART busy model: busy rises 3 cycles into a request and stays high 10 cycles.
  initial forever begin
    @(negedge clk);
    if (!model_en) begin
      model_busy = 1'b0;
      model_cnt  = 0;
    end else if (model_busy) begin
      model_left--;
      if (model_left == 0) model_busy = 1'b0;
    end else if (tx_d_vld) begin
      model_cnt++;
      if (model_cnt == 3) begin
        model_busy = 1'b1;
        model_left = 10;
        model_cnt  = 0;
      end
    end else begin
      model_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard on each REQ entry and checks the level handshake.
  initial begin
    logic       vp = 1'b0;
    logic [7:0] held = 8'h00;
    int         run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        vp  = 1'b0;
        run = 0;
      end else begin
        if (tx_d_vld && !vp) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req got byte %h expected no request", tx_p_data);
          end else begin
            check("tx_byte", {24'h0, tx_p_data}, {24'h0, exp_q.pop_front()});
          end
          held = tx_p_data;
        end else if (tx_d_vld && vp) begin
          check("tx_data_stable", {24'h0, tx_p_data}, {24'h0, held});
        end
        if (vp) begin
          if (tx_busy) check("vld_falls_on_busy", {31'h0, tx_d_vld}, 32'd0);
          else if (!timeout_err) check("vld_holds_until_busy", {31'h0, tx_d_vld}, 32'd1);
        end
        if (timeout_err) begin
          to_count++;
          to_len = run;
        end
        run = tx_d_vld ? run + 1 : 0;
        vp  = tx_d_vld;
      end
    end
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    ovf_clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_tx_d_vld", {31'h0, tx_d_vld}, 32'd0);
    check("rst_tx_p_data", {24'h0, tx_p_data}, 32'd0);
    check("rst_pend", {29'h0, pend}, 32'd0);
    check("rst_ovf", {29'h0, ovf}, 32'd0);
    check("rst_timeout_err", {31'h0, timeout_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin from reset: rf has first priority.
    exp_q.push_back(8'h01); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_q.push_back(8'h7E);
    pulse(1'b1, 8'h01, 1'b1, 16'hBEEF, 1'b1, 8'h7E);
    check("pend_all_captured", {29'h0, pend}, 32'h7);
    wait_idle("rr_round1");
    exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    pulse(1'b1, 8'h02, 1'b0, 16'h0000, 1'b1, 8'h03);
    wait_idle("rr_round2");
    exp_q.push_back(8'h09);
    pulse(1'b1, 8'h09, 1'b0, 16'h0000, 1'b0, 8'h00);
    wait_idle("rr_rf_alone");
    exp_q.push_back(8'h0B); exp_q.push_back(8'h0A);
    pulse(1'b1, 8'h0A, 1'b0, 16'h0000, 1'b1, 8'h0B);
    wait_idle("rr_after_rf");

    // Single rf byte.
    exp_q.push_back(8'hA5);
    pulse(1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0, 8'h00);
    wait_idle("single_rf");
    check("single_rf_pend", {29'h0, pend}, 32'd0);
    check("single_rf_ovf", {29'h0, ovf}, 32'd0);

    // ALU frame with rf pulsed mid-frame.
    exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'h77);
    pulse(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h00);
    wait_vld("alu_low_req", 1'b1);
    pulse(1'b1, 8'h77, 1'b0, 16'h0000, 1'b0, 8'h00);
    wait_idle("alu_frame");

    // vld on the grant cycle refills the slot without overflow.
    exp_q.push_back(8'h81); exp_q.push_back(8'h82);
    @(negedge clk); drive(1'b1, 8'h81, 1'b0, 16'h0000, 1'b0, 8'h00);
    @(negedge clk); drive(1'b1, 8'h82, 1'b0, 16'h0000, 1'b0, 8'h00);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
    check("grant_cycle_no_ovf", {29'h0, ovf}, 32'd0);
    wait_idle("grant_cycle_capture");

    // Overflow while the transmitter is held busy.
    busy_hold = 1'b1;
    exp_q.push_back(8'h55); exp_q.push_back(8'h11);
    pulse(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h55);
    pulse(1'b1, 8'h11, 1'b0, 16'h0000, 1'b0, 8'h00);
    pulse(1'b1, 8'h22, 1'b0, 16'h0000, 1'b0, 8'h00);
    check("ovf_set", {29'h0, ovf}, 32'h1);
    check("ovf_pend_kept", {29'h0, pend}, 32'h1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_clear", {29'h0, ovf}, 32'd0);
    @(negedge clk); ovf_clr = 1'b1; drive(1'b1, 8'h33, 1'b0, 16'h0000, 1'b0, 8'h00);
    @(negedge clk); ovf_clr = 1'b0; drive(1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00);
    check("ovf_set_beats_clr", {29'h0, ovf}, 32'h1);
    busy_hold = 1'b0;
    wait_idle("overflow");

    // Reset in DRAIN of an ALU frame discards the high byte and the queued ack.
    exp_q.push_back(8'hAD);
    pulse(1'b0, 8'h00, 1'b1, 16'hDEAD, 1'b0, 8'h00);
    wait_vld("dead_low_req", 1'b1);
    wait_vld("dead_drain", 1'b0);
    pulse(1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h99);
    check("pre_rst_pend", {29'h0, pend}, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_d_vld", {31'h0, tx_d_vld}, 32'd0);
    check("async_rst_pend", {29'h0, pend}, 32'd0);
    check("async_rst_ovf", {29'h0, ovf}, 32'd0);
    check("async_rst_tx_p_data", {24'h0, tx_p_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    wait_idle("after_reset");

`ifdef TX_ARB_TIMEOUT_EN
    // Busy never rises: the ALU frame is abandoned and the next slot is served.
    model_en = 1'b0;
    exp_q.push_back(8'hFE); exp_q.push_back(8'h5A);
    pulse(1'b0, 8'h00, 1'b1, 16'hCAFE, 1'b0, 8'h00);
    wait_vld("cafe_low_req", 1'b1);
    pulse(1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0, 8'h00);
    begin
      int n = 0;
      while (to_count == 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    model_en = 1'b1;
    check("timeout_req_cycles", to_len, 32'd16);
    wait_idle("timeout_recovery");
    check("timeout_pulses", to_count, 32'd1);
`else
    check("timeout_err_tied_low", to_count, 32'd0);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
